// File: rtl/sparc_exu_div_yctl.sv
// Write-side controller for the per-thread Y registers: tracks WRY, MULScc and
// UMUL/SMUL Y updates down the pipe and decodes the per-thread Y mux selects.
module sparc_exu_div_yctl #(
    parameter int NTHR = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       se,
    input  logic       ifu_exu_wry_e,
    input  logic       ifu_exu_mulscc_e,
    input  logic       ifu_exu_mul_e,
    input  logic       ifu_exu_rdy_e,
    input  logic [3:0] ecl_thr_e,
    input  logic       mulscc_rs1_0_e,
    input  logic       kill_m,
    input  logic       kill_w,
    input  logic       mul_yreg_vld_g,
    output logic [3:0] yctl_wen_w,
    output logic [3:0] yctl_wen_g,
    output logic [3:0] yctl_wen_l,
    output logic [3:0] yctl_shift_g,
    output logic       yctl_data_31_g,
    output logic       yctl_rdy_stall_e,
    output logic       yctl_conflict
);

    localparam logic [3:0] LANE_MASK = 4'((5'd1 << NTHR) - 5'd1);

    function automatic logic is_onehot4(input logic [3:0] x);
        return (x != 4'd0) && ((x & (x - 4'd1)) == 4'd0);
    endfunction

    // Scan is handled by the stage flop library cells, not in this RTL.
    logic unused_se_s;
    assign unused_se_s = se;

    logic [3:0] thr_e_s;
    logic       thr_ok_s;
    logic       wry_e_s, msc_e_s, mul_e_s;

    logic       wry_m_vld_r, wry_w_vld_r, wry_w2_vld_r;
    logic [3:0] wry_m_thr_r, wry_w_thr_r, wry_w2_thr_r;
    logic       msc_m_vld_r, msc_g_vld_r, msc_m_d_r, msc_g_d_r;
    logic [3:0] msc_m_thr_r, msc_g_thr_r;
    logic       mul_m_vld_r, mul_wt_vld_r, mul_wt_new_r;
    logic [3:0] mul_m_thr_r, mul_wt_thr_r;

    logic       msc_live_s, mul_live_s, mul_done_s;
    logic       mul_wt_vld_nx_s, mul_wt_new_nx_s;
    logic [3:0] mul_wt_thr_nx_s;
    logic [3:0] raw_w_s, raw_g_s, raw_s_s, pend_s;

    // Lanes beyond NTHR are masked off; a non-one-hot thread drops the op.
    assign thr_e_s  = ecl_thr_e & LANE_MASK;
    assign thr_ok_s = is_onehot4(thr_e_s);
    assign wry_e_s  = ifu_exu_wry_e & thr_ok_s;
    assign msc_e_s  = ifu_exu_mulscc_e & thr_ok_s;
    assign mul_e_s  = ifu_exu_mul_e & thr_ok_s;

    // MULScc sits in G == W, and a mul's first wait cycle is its W stage.
    assign msc_live_s = msc_g_vld_r & ~kill_w;
    assign mul_live_s = mul_wt_vld_r & ~(mul_wt_new_r & kill_w);
    assign mul_done_s = mul_live_s & mul_yreg_vld_g;

    // Mul wait slot: the multiplier serialises, so one slot holds the mul
    // awaiting Y data; a lost-priority completion is still consumed.
    always_comb begin
        mul_wt_vld_nx_s = mul_wt_vld_r;
        mul_wt_thr_nx_s = mul_wt_thr_r;
        mul_wt_new_nx_s = 1'b0;
        if (mul_m_vld_r && !kill_m && (!mul_live_s || mul_done_s)) begin
            mul_wt_vld_nx_s = 1'b1;
            mul_wt_thr_nx_s = mul_m_thr_r;
            mul_wt_new_nx_s = 1'b1;
        end else if (!mul_live_s || mul_done_s) begin
            mul_wt_vld_nx_s = 1'b0;
            mul_wt_thr_nx_s = 4'd0;
        end else begin
            mul_wt_vld_nx_s = 1'b1;
        end
    end

    // Stage registers for all three pipes.
    always_ff @(posedge clk) begin
        if (reset) begin
            wry_m_vld_r  <= 1'b0;
            wry_w_vld_r  <= 1'b0;
            wry_w2_vld_r <= 1'b0;
            wry_m_thr_r  <= 4'd0;
            wry_w_thr_r  <= 4'd0;
            wry_w2_thr_r <= 4'd0;
            msc_m_vld_r  <= 1'b0;
            msc_g_vld_r  <= 1'b0;
            msc_m_d_r    <= 1'b0;
            msc_g_d_r    <= 1'b0;
            msc_m_thr_r  <= 4'd0;
            msc_g_thr_r  <= 4'd0;
            mul_m_vld_r  <= 1'b0;
            mul_m_thr_r  <= 4'd0;
            mul_wt_vld_r <= 1'b0;
            mul_wt_new_r <= 1'b0;
            mul_wt_thr_r <= 4'd0;
        end else begin
            wry_m_vld_r  <= wry_e_s;
            wry_m_thr_r  <= thr_e_s;
            wry_w_vld_r  <= wry_m_vld_r & ~kill_m;
            wry_w_thr_r  <= wry_m_thr_r;
            wry_w2_vld_r <= wry_w_vld_r & ~kill_w;
            wry_w2_thr_r <= wry_w_thr_r;
            msc_m_vld_r  <= msc_e_s;
            msc_m_thr_r  <= thr_e_s;
            msc_m_d_r    <= mulscc_rs1_0_e;
            msc_g_vld_r  <= msc_m_vld_r & ~kill_m;
            msc_g_thr_r  <= msc_m_thr_r;
            msc_g_d_r    <= msc_m_d_r;
            mul_m_vld_r  <= mul_e_s;
            mul_m_thr_r  <= thr_e_s;
            mul_wt_vld_r <= mul_wt_vld_nx_s;
            mul_wt_thr_r <= mul_wt_thr_nx_s;
            mul_wt_new_r <= mul_wt_new_nx_s;
        end
    end

    assign raw_w_s = {4{wry_w2_vld_r}} & wry_w2_thr_r;
    assign raw_g_s = {4{mul_done_s}} & mul_wt_thr_r;
    assign raw_s_s = {4{msc_live_s}} & msc_g_thr_r;

    // Priority wen_w > wen_g > shift_g within a thread; exactly one select per lane.
    assign yctl_wen_w     = raw_w_s;
    assign yctl_wen_g     = raw_g_s & ~raw_w_s;
    assign yctl_shift_g   = raw_s_s & ~raw_w_s & ~raw_g_s;
    assign yctl_wen_l     = ~(yctl_wen_w | yctl_wen_g | yctl_shift_g);
    assign yctl_conflict  = |((raw_w_s & raw_g_s) | (raw_w_s & raw_s_s) | (raw_g_s & raw_s_s));
    assign yctl_data_31_g = msc_live_s & msc_g_d_r;

    // Pending writes beyond E; the RDY's own E slot never stalls itself.
    assign pend_s = ({4{wry_m_vld_r}}  & wry_m_thr_r)  |
                    ({4{wry_w_vld_r}}  & wry_w_thr_r)  |
                    ({4{wry_w2_vld_r}} & wry_w2_thr_r) |
                    ({4{msc_m_vld_r}}  & msc_m_thr_r)  |
                    ({4{msc_g_vld_r}}  & msc_g_thr_r)  |
                    ({4{mul_m_vld_r}}  & mul_m_thr_r)  |
                    ({4{mul_wt_vld_r}} & mul_wt_thr_r);

    assign yctl_rdy_stall_e = ifu_exu_rdy_e & (|(thr_e_s & pend_s));

endmodule

// File: tb/tb_sparc_exu_div_yctl.sv
// Directed bench for sparc_exu_div_yctl: stimulus pushes per-cycle expected
// selects into a queue; a negedge monitor pops and compares.
module tb_sparc_exu_div_yctl;

    logic       clk = 1'b0;
    logic       reset, se;
    logic       wry_e, mulscc_e, mul_e, rdy_e, rs1_0, kill_m, kill_w, vld_g;
    logic [3:0] thr_e;
    logic [3:0] wen_w, wen_g, wen_l, shift_g;
    logic       data_31, stall, conflict;

    typedef struct {
        int          cyc;
        string       nm;
        logic [18:0] v;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    sparc_exu_div_yctl #(.NTHR(4)) dut (
        .clk(clk), .reset(reset), .se(se),
        .ifu_exu_wry_e(wry_e), .ifu_exu_mulscc_e(mulscc_e), .ifu_exu_mul_e(mul_e),
        .ifu_exu_rdy_e(rdy_e), .ecl_thr_e(thr_e), .mulscc_rs1_0_e(rs1_0),
        .kill_m(kill_m), .kill_w(kill_w), .mul_yreg_vld_g(vld_g),
        .yctl_wen_w(wen_w), .yctl_wen_g(wen_g), .yctl_wen_l(wen_l),
        .yctl_shift_g(shift_g), .yctl_data_31_g(data_31),
        .yctl_rdy_stall_e(stall), .yctl_conflict(conflict)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation scheduled for the current cycle.
    always @(negedge clk) begin
        logic [18:0] got;
        got = {wen_w, wen_g, wen_l, shift_g, data_31, stall, conflict};
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (e.cyc != cyc || got !== e.v) begin
                errors++;
                $display("FAIL %s cyc=%0d got w/g/l/sh/d/st/cf=%b_%b_%b_%b_%b_%b_%b exp=%b_%b_%b_%b_%b_%b_%b",
                         e.nm, e.cyc, got[18:15], got[14:11], got[10:7], got[6:3], got[2], got[1], got[0],
                         e.v[18:15], e.v[14:11], e.v[10:7], e.v[6:3], e.v[2], e.v[1], e.v[0]);
            end
        end
    end

    task automatic ex(input int c, input string nm, input logic [3:0] ww, input logic [3:0] wg,
                      input logic [3:0] sh, input logic d, input logic st, input logic cf);
        exp_t e;
        e.cyc = c;
        e.nm  = nm;
        e.v   = {ww, wg, ~(ww | wg | sh), sh, d, st, cf};
        q.push_back(e);
    endtask

    task automatic exi(input int c0, input int c1, input string nm);
        for (int c = c0; c <= c1; c++) ex(c, nm, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // One cycle of stimulus: {wry,mulscc,mul,rdy}, thread, rs1[0], {kill_m,kill_w,vld_g,reset}.
    task automatic drv(input logic [3:0] op, input logic [3:0] thr, input logic rs1, input logic [3:0] ctl);
        {wry_e, mulscc_e, mul_e, rdy_e} = op;
        thr_e = thr;
        rs1_0 = rs1;
        {kill_m, kill_w, vld_g, reset} = ctl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(4'b0000, 4'b0000, 1'b0, 4'b0000);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int b;
        se = 1'b0;
        drv(4'b0000, 4'b0000, 1'b0, 4'b0001);
        ex(cyc, "reset", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        drv(4'b0000, 4'b0000, 1'b0, 4'b0001);
        idle(2);

        // WRY thr1, no kill: select in W2 only.
        b = cyc;
        exi(b, b + 2, "wry_idle");
        ex(b + 3, "wry_w2", 4'b0010, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        exi(b + 4, b + 5, "wry_after");
        drv(4'b1000, 4'b0010, 1'b0, 4'b0000);
        idle(6);

        // WRY thr2 killed in W.
        b = cyc;
        exi(b, b + 5, "wry_killw");
        drv(4'b1000, 4'b0100, 1'b0, 4'b0000);
        idle(1);
        drv(4'b0000, 4'b0000, 1'b0, 4'b0100);
        idle(4);

        // MULScc thr0, rs1[0]=1.
        b = cyc;
        exi(b, b + 1, "msc_idle");
        ex(b + 2, "msc_g", 4'd0, 4'd0, 4'b0001, 1'b1, 1'b0, 1'b0);
        exi(b + 3, b + 4, "msc_after");
        drv(4'b0100, 4'b0001, 1'b1, 4'b0000);
        idle(5);

        // MULScc killed in M.
        b = cyc;
        exi(b, b + 4, "msc_killm");
        drv(4'b0100, 4'b0001, 1'b1, 4'b0000);
        drv(4'b0000, 4'b0000, 1'b0, 4'b1000);
        idle(4);

        // WRY thr3 then RDY thr3 held: stall until Y committed.
        b = cyc;
        ex(b, "stall_e0", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        ex(b + 1, "stall_m", 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        ex(b + 2, "stall_w", 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        ex(b + 3, "stall_w2", 4'b1000, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        ex(b + 4, "stall_clr", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        drv(4'b1000, 4'b1000, 1'b0, 4'b0000);
        for (int i = 0; i < 4; i++) drv(4'b0001, 4'b1000, 1'b0, 4'b0000);
        idle(2);

        // WRY thr3, RDY from another thread: no stall.
        b = cyc;
        exi(b, b + 2, "rdy_other");
        ex(b + 3, "rdy_other_w2", 4'b1000, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        drv(4'b1000, 4'b1000, 1'b0, 4'b0000);
        drv(4'b0001, 4'b0001, 1'b0, 4'b0000);
        idle(4);

        // WRY thr1 vs MUL thr1 completing same cycle: WRY wins, conflict.
        b = cyc;
        exi(b, b + 2, "conf_idle");
        ex(b + 3, "conf_same", 4'b0010, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        exi(b + 4, b + 5, "conf_drop");
        drv(4'b1000, 4'b0010, 1'b0, 4'b0000);
        drv(4'b0010, 4'b0010, 1'b0, 4'b0000);
        idle(1);
        drv(4'b0000, 4'b0000, 1'b0, 4'b0010);
        idle(3);

        // WRY thr2 and MUL thr1 same cycle: both granted.
        b = cyc;
        exi(b, b + 2, "dual_idle");
        ex(b + 3, "dual_grant", 4'b0100, 4'b0010, 4'd0, 1'b0, 1'b0, 1'b0);
        exi(b + 4, b + 4, "dual_after");
        drv(4'b1000, 4'b0100, 1'b0, 4'b0000);
        drv(4'b0010, 4'b0010, 1'b0, 4'b0000);
        idle(1);
        drv(4'b0000, 4'b0000, 1'b0, 4'b0010);
        idle(3);

        // Long mul wait thr0: RDY stalls while waiting, select on vld_g.
        b = cyc;
        exi(b, b + 2, "mwait_idle");
        ex(b + 3, "mwait_stall", 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        exi(b + 4, b + 4, "mwait_hold");
        ex(b + 5, "mwait_done", 4'd0, 4'b0001, 4'd0, 1'b0, 1'b0, 1'b0);
        exi(b + 6, b + 6, "mwait_after");
        drv(4'b0010, 4'b0001, 1'b0, 4'b0000);
        idle(2);
        drv(4'b0001, 4'b0001, 1'b0, 4'b0000);
        idle(1);
        drv(4'b0000, 4'b0000, 1'b0, 4'b0010);
        idle(3);

        // Non-one-hot thread: op dropped.
        b = cyc;
        exi(b, b + 4, "bad_thr");
        drv(4'b1000, 4'b0011, 1'b0, 4'b0000);
        idle(5);

        // Reset mid-flight drops MUL and WRY.
        b = cyc;
        exi(b, b + 5, "rst_flight");
        drv(4'b0010, 4'b0100, 1'b0, 4'b0000);
        drv(4'b1000, 4'b0010, 1'b0, 4'b0001);
        drv(4'b0001, 4'b0010, 1'b0, 4'b0000);
        drv(4'b0001, 4'b0010, 1'b0, 4'b0010);
        drv(4'b0001, 4'b0010, 1'b0, 4'b0000);
        idle(3);

        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover %0d expectations unchecked, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
